// File: rtl/ws2812b_frame_scheduler.sv
`timescale 1ns/1ps
// ws2812b_frame_scheduler
//   Frame sequencer for a WS2812B LED panel. Reads one 24-bit {G,R,B} pixel at a
//   time from a double-buffered frame RAM. Hands the three bytes to the bit
//   serializer over valid/ready, in G, R, B order. Holds the line in latch
//   (reset) for LATCH_CYCLES, then waits until FRAME_CYCLES have elapsed since
//   the frame started. Owns the displayed-buffer select and only swaps it at the
//   end of a frame.
//
//   Ports
//     clk_i, rst_i          clock, synchronous active-high reset
//     start_i               level: run frames back to back while high
//     swap_req_i/swap_ack_o buffer swap request (held) / 1-cycle grant
//     buf_sel_o             frame buffer being displayed
//     rd_en_o, rd_addr_o    frame RAM read strobe and pixel index
//     rd_data_i             {G,R,B}, valid the cycle after rd_en_o
//     byte_o, byte_valid_o, byte_ready_i   byte stream to the serializer
//     latch_o               high during the inter-frame latch gap
//     busy_o                high whenever not idle
//     frame_done_o          pulse on the last latch cycle
//
//   Optional feature: define WS2812B_SCHED_BRIGHTNESS_EN to add brightness_i
//   (8 bit). Each fetched byte is then scaled by (brightness_i+1)/256.
//   brightness_i is sampled once per frame, when pixel 0 is fetched.
module ws2812b_frame_scheduler #(
  parameter int NUM_LED      = 768,
  parameter int ADDR_W       = 10,
  parameter int LATCH_CYCLES = 5000,
  parameter int FRAME_CYCLES = 1666667
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              swap_req_i,
  output logic              swap_ack_o,
  output logic              buf_sel_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [23:0]       rd_data_i,
  output logic [7:0]        byte_o,
  output logic              byte_valid_o,
  input  logic              byte_ready_i,
  output logic              latch_o,
  output logic              busy_o,
  output logic              frame_done_o
`ifdef WS2812B_SCHED_BRIGHTNESS_EN
  ,
  input  logic [7:0]        brightness_i
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SEND, S_LATCH, S_HOLD} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_LED - 1);
  localparam logic [31:0]       LATCH_LAST = 32'(LATCH_CYCLES - 1);
  localparam logic [31:0]       FRAME_LAST = 32'(FRAME_CYCLES - 1);

  // Frame-period counter must never wrap back to a small value, so it sticks at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

`ifdef WS2812B_SCHED_BRIGHTNESS_EN
  // byte * (br + 1) >> 8; max product 255*256 fits in 16 bits, so br=0xFF is identity.
  function automatic logic [7:0] scale_byte(input logic [7:0] b, input logic [7:0] br);
    logic [16:0] p;
    p = 17'(b) * (17'(br) + 17'd1);
    return p[15:8];
  endfunction
  logic [7:0] bright_q, bright_d;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       latch_cnt_q, latch_cnt_d;
  logic [31:0]       frame_cnt_q, frame_cnt_d;
  logic              buf_sel_q, buf_sel_d;
  logic [23:0]       hold_q, hold_d;

  // Control state: reset applies here only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      byte_idx_q  <= '0;
      latch_cnt_q <= '0;
      frame_cnt_q <= '0;
      buf_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      byte_idx_q  <= byte_idx_d;
      latch_cnt_q <= latch_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      buf_sel_q   <= buf_sel_d;
    end
  end

  // Pixel data path: no reset, byte_o is gated by state instead.
  always_ff @(posedge clk_i) begin
    hold_q <= hold_d;
`ifdef WS2812B_SCHED_BRIGHTNESS_EN
    bright_q <= bright_d;
`endif
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    byte_idx_d   = byte_idx_q;
    latch_cnt_d  = latch_cnt_q;
    buf_sel_d    = buf_sel_q;
    hold_d       = hold_q;
`ifdef WS2812B_SCHED_BRIGHTNESS_EN
    bright_d     = bright_q;
`endif
    // Counts from the FETCH of pixel 0 onward; parked while idle.
    frame_cnt_d  = (state_q == S_IDLE) ? frame_cnt_q : sat_inc(frame_cnt_q);
    rd_en_o      = 1'b0;
    byte_o       = 8'h00;
    byte_valid_o = 1'b0;
    latch_o      = 1'b0;
    frame_done_o = 1'b0;
    swap_ack_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_FETCH;
          addr_d      = '0;
          frame_cnt_d = '0;
        end
      end
      S_FETCH: begin
        rd_en_o = 1'b1;
        state_d = S_WAIT;
`ifdef WS2812B_SCHED_BRIGHTNESS_EN
        if (addr_q == '0) bright_d = brightness_i;
`endif
      end
      S_WAIT: begin
`ifdef WS2812B_SCHED_BRIGHTNESS_EN
        hold_d = {scale_byte(rd_data_i[23:16], bright_q),
                  scale_byte(rd_data_i[15:8],  bright_q),
                  scale_byte(rd_data_i[7:0],   bright_q)};
`else
        hold_d = rd_data_i;
`endif
        byte_idx_d = 2'd0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        byte_valid_o = 1'b1;
        case (byte_idx_q)
          2'd0:    byte_o = hold_q[23:16];
          2'd1:    byte_o = hold_q[15:8];
          default: byte_o = hold_q[7:0];
        endcase
        if (byte_ready_i) begin
          if (byte_idx_q != 2'd2) begin
            byte_idx_d = byte_idx_q + 2'd1;
          end else if (addr_q != LAST_ADDR) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_FETCH;
          end else begin
            latch_cnt_d = '0;
            state_d     = S_LATCH;
          end
        end
      end
      S_LATCH: begin
        latch_o = 1'b1;
        if (latch_cnt_q == LATCH_LAST) begin
          frame_done_o = 1'b1;
          state_d      = S_HOLD;
          // Only point where the displayed buffer may change; a reset in the
          // same cycle suppresses the grant.
          if (swap_req_i) begin
            swap_ack_o = !rst_i;
            buf_sel_d  = !buf_sel_q;
          end
        end else begin
          latch_cnt_d = latch_cnt_q + 32'd1;
        end
      end
      S_HOLD: begin
        if (frame_cnt_q >= FRAME_LAST) begin
          frame_cnt_d = '0;
          addr_d      = '0;
          state_d     = start_i ? S_FETCH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_addr_o = addr_q;
  assign buf_sel_o = buf_sel_q;
  assign busy_o    = (state_q != S_IDLE);

endmodule
